// File: rtl/vx_bpif_mem_pkg.sv
// Shared definitions for the bpif-to-Vortex memory initiator.
// Provides the FSM state type, line/word/tag geometry and the default timeout.
package vx_bpif_mem_pkg;

  localparam int unsigned LineAddrW      = 26;  // 64-byte line address
  localparam int unsigned WordIdxW       = 4;   // 16 x 32-bit words per line
  localparam int unsigned WordsPerLine   = 16;
  localparam int unsigned TagCntW        = 4;   // issued tag counter width
  localparam int unsigned TimeoutDefault = 256;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/bus_protocol_if.sv
// Host-side bus protocol interface.
// peripheral_vital modport: wen, ren, addr, wdata, strobe in; rdata, error, request_stall out.
interface bus_protocol_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    wen;
  logic                    ren;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    error;
  logic                    request_stall;

  modport peripheral_vital (
    input  wen, ren, addr, wdata, strobe,
    output rdata, error, request_stall
  );

endinterface

// File: rtl/vx_line_buffer.sv
// Single-line read buffer.
// Holds one memory line (valid, line address, data). Supports invalidate, full-line fill,
// byte-merge of a write to the buffered line, and combinational hit/word lookup.
//   inval_i                  : drop the buffered line (highest priority)
//   fill_i/fill_*            : load a complete line
//   merge_i/merge_*          : write-through byte merge, applied only if the line matches
//   lookup_line_i/word_i     : hit_o and selected word_o
module vx_line_buffer
  import vx_bpif_mem_pkg::*;
#(
  parameter int unsigned LineAddrWidth = LineAddrW,
  parameter int unsigned LineDataWidth = 512,
  parameter int unsigned WordWidth     = 32,
  localparam int unsigned WordSelW     = $clog2(LineDataWidth / WordWidth)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       inval_i,
  input  logic                       fill_i,
  input  logic [LineAddrWidth-1:0]   fill_line_i,
  input  logic [LineDataWidth-1:0]   fill_data_i,
  input  logic                       merge_i,
  input  logic [LineAddrWidth-1:0]   merge_line_i,
  input  logic [LineDataWidth/8-1:0] merge_byteen_i,
  input  logic [LineDataWidth-1:0]   merge_data_i,
  input  logic [LineAddrWidth-1:0]   lookup_line_i,
  input  logic [WordSelW-1:0]        lookup_word_i,
  output logic                       hit_o,
  output logic [WordWidth-1:0]       word_o
);

  logic                     valid_q, valid_d;
  logic [LineAddrWidth-1:0] line_q, line_d;
  logic [LineDataWidth-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    line_d  = line_q;
    data_d  = data_q;
    if (inval_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      line_d  = fill_line_i;
      data_d  = fill_data_i;
    end else if (merge_i && valid_q && (line_q == merge_line_i)) begin
      for (int unsigned b = 0; b < LineDataWidth / 8; b++) begin
        if (merge_byteen_i[b]) data_d[b*8 +: 8] = merge_data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      line_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      line_q  <= line_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (line_q == lookup_line_i);
  assign word_o = data_q[lookup_word_i*WordWidth +: WordWidth];

endmodule

// File: rtl/vx_bpif_mem_initiator.sv
// Bridges single-word bpif host accesses onto the Vortex line-wide memory interface.
// One transaction outstanding; a one-line read buffer serves zero-stall read hits and is
// kept coherent by write-through merging. Timeouts and ren&wen conflicts end in error.
//   clk, nRST                      : clock, asynchronous active-low reset
//   bpif                           : host port (peripheral_vital)
//   mem_req_*                      : line request (valid/rw/byteen/addr/data/tag, ready in)
//   mem_rsp_*                      : line read response (valid/data/tag in, ready out)
module vx_bpif_mem_initiator
  import vx_bpif_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned VX_MEM_ADDR_WIDTH = LineAddrW,
  parameter int unsigned VX_MEM_DATA_WIDTH = 512,
  parameter int unsigned VX_MEM_TAG_WIDTH  = 56,
  parameter int unsigned TIMEOUT_CYCLES    = TimeoutDefault
) (
  input  logic                           clk,
  input  logic                           nRST,
  bus_protocol_if.peripheral_vital       bpif,
  output logic                           mem_req_valid,
  output logic                           mem_req_rw,
  output logic [VX_MEM_DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [VX_MEM_ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [VX_MEM_DATA_WIDTH-1:0]   mem_req_data,
  output logic [VX_MEM_TAG_WIDTH-1:0]    mem_req_tag,
  input  logic                           mem_req_ready,
  input  logic                           mem_rsp_valid,
  input  logic [VX_MEM_DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [VX_MEM_TAG_WIDTH-1:0]    mem_rsp_tag,
  output logic                           mem_rsp_ready
);

  localparam int unsigned ByteW     = DATA_WIDTH / 8;
  localparam int unsigned LineBytes = VX_MEM_DATA_WIDTH / 8;
  localparam int unsigned WordLsb   = $clog2(ByteW);
  localparam int unsigned LineLsb   = $clog2(LineBytes);
  localparam int unsigned TmoW      = $clog2(TIMEOUT_CYCLES) + 1;

  state_e                       state_q, state_d;
  logic [TagCntW-1:0]           tag_q, tag_d;
  logic [TmoW-1:0]              tmo_q, tmo_d;
  logic                         rw_q, rw_d;
  logic [VX_MEM_ADDR_WIDTH-1:0] line_q, line_d;
  logic [WordIdxW-1:0]          word_q, word_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [ByteW-1:0]             strb_q, strb_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                         err_q, err_d;

  logic [VX_MEM_ADDR_WIDTH-1:0] in_line;
  logic [WordIdxW-1:0]          in_word;
  logic                         buf_hit, buf_fill, buf_merge, buf_inval;
  logic [DATA_WIDTH-1:0]        buf_word;
  logic                         rsp_match, timeout, host_req;
  logic                         stall, err_out;
  logic [DATA_WIDTH-1:0]        rdata_out;
  logic                         unused_addr;

  assign in_line     = bpif.addr[LineLsb +: VX_MEM_ADDR_WIDTH];
  assign in_word     = bpif.addr[WordLsb +: WordIdxW];
  assign unused_addr = ^bpif.addr[WordLsb-1:0];
  assign host_req    = bpif.ren | bpif.wen;

  // Payload comes only from registers so it stays stable while waiting for ready.
  assign mem_req_rw     = rw_q;
  assign mem_req_addr   = line_q;
  assign mem_req_byteen = rw_q ? (LineBytes'(strb_q) << (ByteW * word_q)) : '1;
  assign mem_req_data   = {(VX_MEM_DATA_WIDTH / DATA_WIDTH){wdata_q}};
  assign mem_req_tag    = VX_MEM_TAG_WIDTH'(tag_q);

  // The counter has already advanced past the issued tag once we are in StWait.
  assign rsp_match = mem_rsp_valid &&
                     (mem_rsp_tag == VX_MEM_TAG_WIDTH'(tag_q - TagCntW'(1)));
  assign timeout   = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    tmo_d         = tmo_q;
    rw_d          = rw_q;
    line_d        = line_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    stall         = 1'b0;
    rdata_out     = '0;
    err_out       = 1'b0;
    buf_fill      = 1'b0;
    buf_merge     = 1'b0;
    buf_inval     = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_rsp_ready = 1'b1;  // stray responses are swallowed here
        if (bpif.ren && bpif.wen) begin
          stall   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else if (bpif.ren && buf_hit) begin
          rdata_out = buf_word;
        end else if (host_req) begin
          stall   = 1'b1;
          rw_d    = bpif.wen;
          line_d  = in_line;
          word_d  = in_word;
          wdata_d = bpif.wdata;
          strb_d  = bpif.strobe;
          tmo_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        mem_req_valid = 1'b1;
        stall         = host_req;
        tmo_d         = tmo_q + TmoW'(1);
        if (mem_req_ready) begin
          tag_d = tag_q + TagCntW'(1);
          if (rw_q) begin
            buf_merge = 1'b1;
            err_d     = 1'b0;
            rdata_d   = '0;
            state_d   = StDone;
          end else begin
            state_d = StWait;
          end
        end else if (timeout) begin
          tag_d     = tag_q + TagCntW'(1);  // abandoned request still consumes its tag
          buf_inval = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          state_d   = StDone;
        end
      end
      StWait: begin
        mem_rsp_ready = 1'b1;
        stall         = host_req;
        tmo_d         = tmo_q + TmoW'(1);
        if (rsp_match) begin
          buf_fill = 1'b1;
          rdata_d  = mem_rsp_data[word_q*DATA_WIDTH +: DATA_WIDTH];
          err_d    = 1'b0;
          state_d  = StDone;
        end else if (timeout) begin
          buf_inval = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          state_d   = StDone;
        end
      end
      StDone: begin
        rdata_out = rdata_q;
        err_out   = err_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      tag_q   <= '0;
      tmo_q   <= '0;
      rw_q    <= 1'b0;
      line_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      tmo_q   <= tmo_d;
      rw_q    <= rw_d;
      line_q  <= line_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bpif.request_stall = stall;
  assign bpif.rdata         = rdata_out;
  assign bpif.error         = err_out;

  vx_line_buffer #(
    .LineAddrWidth (VX_MEM_ADDR_WIDTH),
    .LineDataWidth (VX_MEM_DATA_WIDTH),
    .WordWidth     (DATA_WIDTH)
  ) u_line_buffer (
    .clk_i          (clk),
    .rst_ni         (nRST),
    .inval_i        (buf_inval),
    .fill_i         (buf_fill),
    .fill_line_i    (line_q),
    .fill_data_i    (mem_rsp_data),
    .merge_i        (buf_merge),
    .merge_line_i   (line_q),
    .merge_byteen_i (mem_req_byteen),
    .merge_data_i   (mem_req_data),
    .lookup_line_i  (in_line),
    .lookup_word_i  (in_word),
    .hit_o          (buf_hit),
    .word_o         (buf_word)
  );

endmodule
